mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one memory port between an instruction-fetch requester and a
//   data (lw/sw) requester. Data has priority in IDLE, but a requester is never
//   re-granted in the cycle its own done is high, so under continuous traffic
//   the two requesters alternate and fetch always makes progress.
//
// Handshake (all requester and memory sides):
//   A requester raises *Req with stable address/data and holds it until its
//   *Done pulse (one cycle). The grant latches the request into the memory-side
//   registers and memReq rises the cycle after the request is sampled. memReq
//   and the latched fields stay constant until memReady is sampled high (a
//   one-cycle completion); done pulses the following cycle. memReady is
//   ignored while idle. Dropping *Req mid-transaction does not cancel it.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ifReq, ifAddr         fetch request and address
//   ifDone, ifRdata       fetch completion pulse and fetched word
//   dReq, dWe, dAddr,     data request, store enable, address, store data
//   dWdata
//   dDone, dRdata         data completion pulse and load data
//   memReq, memWe,        registered memory request, write enable, address,
//   memAddr, memWdata     write data (address/data/we read 0 when idle)
//   memRdata, memReady    memory read data and one-cycle completion
//   timeoutErr            sticky watchdog error flag
//
// Configuration:
//   ARB_TIMEOUT_EN  when defined, a watchdog aborts a transaction that has spent
//                   TIMEOUT_CYCLES cycles waiting for memReady: done pulses with
//                   read data 0 and timeoutErr is set until reset. When not
//                   defined there is no counter and timeoutErr is tied to 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic        ifDone,
    output logic [31:0] ifRdata,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic        dDone,
    output logic [31:0] dRdata,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memReady,
    output logic        timeoutErr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        busy;
    logic        finish;
    logic [31:0] finish_data;
    logic        grant_data;
    logic        grant_fetch;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value during the last cycle allowed to wait for memReady.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             timed_out;
`endif

    assign busy = (state_q == FETCH) || (state_q == DATA);

    // A requester whose done is high this cycle is still holding its request
    // (it only sees done now), so it must not win again; the other may.
    assign grant_data  = (state_q == IDLE) && dReq && !d_done_q;
    assign grant_fetch = (state_q == IDLE) && ifReq && !if_done_q && !grant_data;

`ifdef ARB_TIMEOUT_EN
    assign timed_out   = busy && !memReady && (cnt_q == CNT_LAST);
    assign finish      = busy && (memReady || timed_out);
    assign finish_data = timed_out ? 32'h0 : memRdata;
`else
    assign finish      = busy && memReady;
    assign finish_data = memRdata;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dWe;
                    mem_addr_d  = dAddr;
                    mem_wdata_d = dWdata;
                end else if (grant_fetch) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ifAddr;
                    mem_wdata_d = 32'h0;
                end
            end
            FETCH, DATA: begin
                if (finish) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    if (state_q == FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = finish_data;
                    end else begin
                        d_done_d = 1'b1;
                        // Stores leave the last load value visible.
                        if (!mem_we_q) begin
                            d_rdata_d = finish_data;
                        end
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'h0;
                mem_wdata_d = 32'h0;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        cnt_d         = (busy && !finish) ? cnt_q + 1'b1 : '0;
        timeout_err_d = timeout_err_q | timed_out;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeoutErr = timeout_err_q;
`else
    assign timeoutErr = 1'b0;
`endif

    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign ifDone   = if_done_q;
    assign ifRdata  = if_rdata_q;
    assign dDone    = d_done_q;
    assign dRdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (lone fetch, simultaneous requests, store, dropped
// request, continuous alternation, reset mid-transaction, watchdog when
// ARB_TIMEOUT_EN is defined) followed by randomized traffic. A
// transaction-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TO = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ifReq, dReq, dWe, memReady;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;
  logic        ifDone, dDone, memReq, memWe, timeoutErr;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ifReq      (ifReq),
    .ifAddr     (ifAddr),
    .ifDone     (ifDone),
    .ifRdata    (ifRdata),
    .dReq       (dReq),
    .dWe        (dWe),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .dDone      (dDone),
    .dRdata     (dRdata),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memRdata   (memRdata),
    .memReady   (memReady),
    .timeoutErr (timeoutErr)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one outstanding transaction, owner 0=none 1=fetch 2=data
  // ---------------------------------------------------------------------------
  int          m_owner;
  int          m_busy;
  logic        m_we, m_if_done, m_d_done, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

  task automatic model_reset();
    m_owner = 0; m_busy = 0; m_we = 0; m_if_done = 0; m_d_done = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
  endtask

  task automatic retire(input logic [31:0] data);
    if (m_owner == 1) begin
      m_if_done  = 1'b1;
      m_if_rdata = data;
    end else begin
      m_d_done = 1'b1;
      if (!m_we) m_d_rdata = data;
    end
    m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0;
  endtask

  // Advance the model across one rising edge using the inputs about to be sampled.
  task automatic model_step();
    logic prev_if_done, prev_d_done;
    prev_if_done = m_if_done;
    prev_d_done  = m_d_done;
    m_if_done = 1'b0;
    m_d_done  = 1'b0;
    if (m_owner != 0) begin
      m_busy++;
      if (memReady) retire(memRdata);
`ifdef ARB_TIMEOUT_EN
      else if (m_busy >= TO) begin
        retire(32'h0);
        m_err = 1'b1;
      end
`endif
    end else if (dReq && !prev_d_done) begin
      m_owner = 2; m_we = dWe; m_addr = dAddr; m_wdata = dWdata; m_busy = 0;
    end else if (ifReq && !prev_if_done) begin
      m_owner = 1; m_we = 1'b0; m_addr = ifAddr; m_wdata = 32'h0; m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("memReq",     memReq,     m_owner != 0);
    check_eq("memWe",      memWe,      m_we);
    check_eq("memAddr",    memAddr,    m_addr);
    check_eq("memWdata",   memWdata,   m_wdata);
    check_eq("ifDone",     ifDone,     m_if_done);
    check_eq("dDone",      dDone,      m_d_done);
    check_eq("ifRdata",    ifRdata,    m_if_rdata);
    check_eq("dRdata",     dRdata,     m_d_rdata);
    check_eq("timeoutErr", timeoutErr, m_err);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    ifReq = 0; dReq = 0; dWe = 0; memReady = 0;
  endtask

  // Assert reset between edges, then release it on a falling edge.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_async_memReq", memReq, 1'b0);
    check_eq("rst_async_dDone",  dDone,  1'b0);
    check_outputs();
    idle_inputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    ifReq = 0; dReq = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_owner == 0 && !m_if_done && !m_d_done) break;
      memReady = (m_owner != 0);
      tick();
    end
    memReady = 0;
    check_eq("drain_idle", memReq, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic f_active, f_drop, d_active, d_drop, prev_req;

  initial begin
    reset = 1'b1;
    idle_inputs();
    ifAddr = 0; dAddr = 0; dWdata = 0; memRdata = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Lone fetch, memReady two cycles after memReq.
    ifAddr = 32'h0040_0000; ifReq = 1;
    tick();
    check_eq("lone_memAddr", memAddr, 32'h0040_0000);
    memReady = 0; tick();
    memReady = 0; tick();
    memReady = 1; memRdata = 32'h2008_0005; tick();
    check_eq("lone_ifDone",  ifDone,  1'b1);
    check_eq("lone_ifRdata", ifRdata, 32'h2008_0005);
    ifReq = 0; memReady = 0; tick();
    check_eq("lone_ifDone_pulse", ifDone, 1'b0);

    // Simultaneous fetch and load: data first, fetch granted in the dDone cycle.
    ifAddr = 32'h0040_0004; ifReq = 1;
    dAddr = 32'h1001_0000; dWe = 0; dReq = 1;
    tick();
    check_eq("sim_first_addr", memAddr, 32'h1001_0000);
    memReady = 1; memRdata = 32'h1234_5678; tick();
    check_eq("sim_dDone",  dDone,  1'b1);
    check_eq("sim_dRdata", dRdata, 32'h1234_5678);
    dReq = 0; memReady = 0; tick();
    check_eq("sim_fetch_req",  memReq,  1'b1);
    check_eq("sim_fetch_addr", memAddr, 32'h0040_0004);
    memReady = 1; memRdata = 32'h0badc0de; tick();
    ifReq = 0; memReady = 0; tick();

    // Store leaves dRdata untouched.
    dReq = 1; dWe = 1; dAddr = 32'h1001_0004; dWdata = 32'hDEAD_BEEF;
    tick();
    check_eq("st_memWe",    memWe,    1'b1);
    check_eq("st_memWdata", memWdata, 32'hDEAD_BEEF);
    memReady = 1; memRdata = 32'hCAFE_F00D; tick();
    check_eq("st_dDone",  dDone,  1'b1);
    check_eq("st_dRdata", dRdata, 32'h1234_5678);
    dReq = 0; dWe = 0; memReady = 0; tick();

    // memReady while idle is ignored.
    memReady = 1; memRdata = 32'h5555_aaaa; tick(); tick();
    memReady = 0;

    // Requester drops its request mid-transaction; done still arrives.
    dReq = 1; dWe = 0; dAddr = 32'h1001_0008; tick();
    dReq = 0; tick();
    memReady = 1; memRdata = 32'h7777_0001; tick();
    check_eq("drop_dDone", dDone, 1'b1);
    memReady = 0; tick();

    // Continuous requests alternate DATA, FETCH, DATA, ...
    ifAddr = 32'h0040_0100; dAddr = 32'h1001_0100; dWe = 0;
    ifReq = 1; dReq = 1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h1001_0100);
      exp_q.push_back(32'h0040_0100);
    end
    prev_req = memReq;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      memReady = (m_owner != 0);
      memRdata = $urandom;
      tick();
      if (memReq && !prev_req) check_eq("alt_grant_addr", memAddr, exp_q.pop_front());
      prev_req = memReq;
    end
    check_eq("alt_grants_left", exp_q.size(), 0);
    drain();

    // Reset in the middle of a data transaction.
    dReq = 1; dWe = 0; dAddr = 32'h1001_0200; tick();
    memReady = 0; tick();
    check_eq("rst_mid_busy", memReq, 1'b1);
    apply_reset();
    tick(); tick();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: memReady withheld for TO cycles.
    ifAddr = 32'h0040_0200; ifReq = 1; memReady = 0; memRdata = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < TO; i++) tick();
    check_eq("to_ifDone",  ifDone,     1'b1);
    check_eq("to_ifRdata", ifRdata,    32'h0);
    check_eq("to_err",     timeoutErr, 1'b1);
    ifReq = 0; tick(); tick();
    check_eq("to_err_sticky", timeoutErr, 1'b1);
`endif

    // Randomized traffic.
    f_active = 0; f_drop = 0; d_active = 0; d_drop = 0;
    for (int c = 0; c < 1500; c++) begin
      if (f_active && m_if_done) begin f_active = 0; f_drop = 0; end
      if (!f_active && $urandom_range(0, 2) == 0) begin
        f_active = 1;
        ifAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (f_active && m_owner == 1 && $urandom_range(0, 15) == 0) f_drop = 1;
      ifReq = f_active && !f_drop;

      if (d_active && m_d_done) begin d_active = 0; d_drop = 0; end
      if (!d_active && $urandom_range(0, 2) == 0) begin
        d_active = 1;
        dWe = $urandom_range(0, 1) == 1;
        dAddr = $urandom & 32'hFFFF_FFFC;
        dWdata = $urandom;
      end
      if (d_active && m_owner == 2 && $urandom_range(0, 15) == 0) d_drop = 1;
      dReq = d_active && !d_drop;

      if (m_owner != 0) memReady = $urandom_range(0, 2) == 0;
      else memReady = $urandom_range(0, 3) == 0;
      memRdata = $urandom;
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
